div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Parametrised multi-cycle restoring integer divider for the EX-stage DIV/DIVU path.
- Retires BITS_PER_CYCLE quotient bits per clock and handles signed and unsigned operands.
- Reports divide-by-zero explicitly; accepts a cancel from the pipeline (flush/exception).
- Holds its result under a done/ack handshake until the HI/LO write-back logic consumes it.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- BITS_PER_CYCLE, 1, quotient bits per iteration; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  request; sampled only in IDLE
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned; captured at start
- dividend_i  in  WIDTH  dividend; captured at start
- divisor_i  in  WIDTH  divisor; captured at start
- cancel_i  in  1  abort the operation in flight
- ack_i  in  1  consumer has taken the result
- busy_o  out  1  high in CALC and FIX
- done_o  out  1  result valid; held until ack_i
- div_zero_o  out  1  divisor was zero; valid with done_o
- quotient_o  out  WIDTH  quotient
- remainder_o  out  WIDTH  remainder

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy_o, done_o, div_zero_o = 0.
  - quotient_o, remainder_o = 0.
  - The internal counter and working registers are cleared.
  - Reset mid-operation discards all work.
- Let N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start_i=1, cancel_i=0 and divisor_i!=0:
    - capture the magnitudes of both operands (negate if signed_i and MSB set);
    - capture signed_i and both operand sign bits;
    - clear the counter; go to CALC.
  - On start_i=1, cancel_i=0 and divisor_i==0:
    - load quotient_o = all ones and remainder_o = dividend_i (raw);
    - set div_zero_o = 1; go to DONE.
  - Otherwise remain in IDLE.
- CALC:
  - Each cycle performs BITS_PER_CYCLE restoring steps.
  - Each step forms partial remainder minus divisor over WIDTH+1 bits:
    - non-negative: commit the difference, shift in quotient bit 1;
    - negative: keep the partial remainder, shift in quotient bit 0.
  - The counter increments once per cycle; after N cycles go to FIX.
- FIX, one cycle:
  - Negate the quotient if signed and the operand signs differ.
  - Negate the remainder if signed and the dividend was negative.
  - Quotient truncates toward zero; the remainder takes the dividend's sign (MIPS semantics).
  - Register the results into quotient_o/remainder_o; go to DONE.
- DONE:
  - done_o = 1; the outputs are stable.
  - On ack_i=1: done_o and div_zero_o drop next cycle; go to IDLE.
  - quotient_o/remainder_o keep their values until the next FIX or div-by-zero load.
- Latency:
  - done_o first rises N+2 cycles after the start_i sampling edge.
  - For a zero divisor, done_o rises 1 cycle after it.
- Cancel:
  - cancel_i=1 in CALC or FIX → IDLE next cycle; busy_o drops; done_o is never raised; outputs are unchanged.
  - cancel_i in DONE is treated as ack_i.
  - cancel_i=1 with start_i in IDLE → the request is rejected.
- start_i outside IDLE is ignored; no queuing.
- In the same DONE cycle, start_i and ack_i together → only ack is honoured; start must be re-presented in IDLE.
- Overflow case: signed MIN / −1 yields quotient = MIN, remainder = 0, with no flag.
- Operand inputs may change after the start cycle without effect.

Decomposition:
- div_pkg holds:
  - the state enum (IDLE/CALC/FIX/DONE);
  - the DIV0_QUOT all-ones constant, as a function of WIDTH;
  - the legality check for BITS_PER_CYCLE.
- Sub-module div_step:
  - one combinational restoring step (WIDTH+1-bit subtract, select, shift);
  - instantiated BITS_PER_CYCLE times in a chain inside div_iter.

Test Plan:
- Unsigned 100/7, WIDTH=32, BPC=1:
  - quotient_o=14, remainder_o=2, div_zero_o=0;
  - done_o rises exactly 34 cycles after start;
  - busy_o is high for 33 cycles.
- Signed −7/2 (0xFFFFFFF9/0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Zero divisor, 5/0:
  - done_o rises 1 cycle after start;
  - quotient 0xFFFFFFFF, remainder 5, div_zero_o=1;
  - ack_i clears done_o and div_zero_o next cycle.
- Cancel 10 cycles into CALC:
  - busy_o drops next cycle; done_o stays 0 for 40 cycles.
  - A following unsigned 0xFFFFFFFF/0x10 → quotient 0x0FFFFFFF, remainder 0xF.
- BPC=4 build, 1000/33:
  - quotient 30, remainder 10, done_o at 10 cycles;
  - holding ack_i low for 5 cycles keeps done_o and the outputs stable;
  - a start_i pulsed in DONE is ignored.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
// Contents: FSM state enum, divide-by-zero quotient constant, and the
// BITS_PER_CYCLE legality check used at elaboration.
package div_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // All-ones quotient reported on a zero divisor, sized down by the caller.
  function automatic logic [MAX_WIDTH-1:0] div0_quot(input int unsigned width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Only 1, 2 or 4 bits per cycle, and the width must split evenly.
  function automatic bit bpc_legal(input int unsigned width, input int unsigned bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && (width % bpc == 0)
           && (width <= MAX_WIDTH) && (width >= 2);
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between the EX stage and the divider.
// Requester side (master): start_i, signed_i, dividend_i, divisor_i,
//   cancel_i, ack_i out; busy_o, done_o, div_zero_o, quotient_o,
//   remainder_o in.  Divider side (slave) is the mirror image.
interface div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             cancel_i;
  logic             ack_i;
  logic             busy_o;
  logic             done_o;
  logic             div_zero_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, cancel_i, ack_i,
    input  busy_o, done_o, div_zero_o, quotient_o, remainder_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, cancel_i, ack_i,
    output busy_o, done_o, div_zero_o, quotient_o, remainder_o
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports: i_rem   partial remainder (always < i_divisor)
//        i_quo   shift register: unconsumed dividend bits high, quotient low
//        i_divisor divisor magnitude
//        o_rem/o_quo updated remainder and shift register
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // Bring down the next dividend bit.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  // Since i_rem < divisor, w_shift < 2*divisor, so bit WIDTH of the
  // WIDTH+1-bit difference is a reliable borrow/sign indicator.
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign w_ge    = ~w_diff[WIDTH];

  assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU (MIPS semantics: quotient
// truncates toward zero, remainder carries the dividend's sign).
// Ports: clk, rst (synchronous, active-high); bus (div_iter_if.slave)
//   carrying start/operands/cancel/ack in and busy/done/div_zero/
//   quotient/remainder out.  Result is held until ack (or cancel) in DONE.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("div_iter: illegal BITS_PER_CYCLE for this WIDTH");
  end

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_signed;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_quot_out;
  logic [WIDTH-1:0] r_rem_out;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_rem [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] w_quo [BITS_PER_CYCLE+1];

  // Operand magnitudes at the start cycle.
  assign w_neg_a   = bus.signed_i & bus.dividend_i[WIDTH-1];
  assign w_neg_b   = bus.signed_i & bus.divisor_i[WIDTH-1];
  assign w_dvd_mag = w_neg_a ? (WIDTH'(0) - bus.dividend_i) : bus.dividend_i;
  assign w_dvs_mag = w_neg_b ? (WIDTH'(0) - bus.divisor_i)  : bus.divisor_i;

  // Chain of restoring steps evaluated each CALC cycle.
  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (w_rem[g]),
      .i_quo     (w_quo[g]),
      .i_divisor (r_dvs),
      .o_rem     (w_rem[g+1]),
      .o_quo     (w_quo[g+1])
    );
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_signed   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_quot_out <= '0;
      r_rem_out  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start_i && !bus.cancel_i) begin
            if (bus.divisor_i == '0) begin
              r_quot_out <= WIDTH'(div0_quot(WIDTH));
              r_rem_out  <= bus.dividend_i;
              r_div_zero <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_quo      <= w_dvd_mag;
              r_rem      <= '0;
              r_dvs      <= w_dvs_mag;
              r_signed   <= bus.signed_i;
              r_sign_a   <= bus.dividend_i[WIDTH-1];
              r_sign_b   <= bus.divisor_i[WIDTH-1];
              r_cnt      <= '0;
              r_div_zero <= 1'b0;
              r_state    <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          if (bus.cancel_i) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_busy <= 1'b1;
            r_rem  <= w_rem[BITS_PER_CYCLE];
            r_quo  <= w_quo[BITS_PER_CYCLE];
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(N - 1)) r_state <= ST_FIX;
          end
        end

        ST_FIX: begin
          if (bus.cancel_i) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_busy     <= 1'b1;
            r_quot_out <= (r_signed && (r_sign_a != r_sign_b)) ? (WIDTH'(0) - r_quo) : r_quo;
            r_rem_out  <= (r_signed && r_sign_a) ? (WIDTH'(0) - r_rem) : r_rem;
            r_state    <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_busy <= 1'b0;
          // Handshake only counts once done_o is actually visible.
          if (r_done && (bus.ack_i || bus.cancel_i)) begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.div_zero_o  = r_div_zero;
  assign bus.quotient_o  = r_quot_out;
  assign bus.remainder_o = r_rem_out;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: a BITS_PER_CYCLE=1 instance driven from
// a vector table plus a cancel sequence, and a BITS_PER_CYCLE=4 instance
// exercising latency, result hold under a late ack, and ignored start.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) bus1 ();
  div_iter_if #(.WIDTH(32)) bus4 ();

  div_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  div_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
    int          busy;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int busy;
    string p;
    p = $sformatf("v%0d", idx);
    bus1.signed_i   = v.sgn;
    bus1.dividend_i = v.a;
    bus1.divisor_i  = v.b;
    bus1.start_i    = 1'b1;
    tick();
    // Operands wander after the start cycle; the result must not care.
    bus1.start_i    = 1'b0;
    bus1.signed_i   = 1'($urandom);
    bus1.dividend_i = $urandom;
    bus1.divisor_i  = $urandom;
    lat  = -1;
    busy = 0;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      tick();
      if (bus1.busy_o) busy++;
      if (bus1.done_o) lat = c;
    end
    chk({p, "_latency"}, 32'(lat), 32'(v.lat));
    chk({p, "_busy_cycles"}, 32'(busy), 32'(v.busy));
    chk({p, "_quotient"}, bus1.quotient_o, v.q);
    chk({p, "_remainder"}, bus1.remainder_o, v.r);
    chk({p, "_div_zero"}, 32'(bus1.div_zero_o), 32'(v.z));
    bus1.ack_i = 1'b1;
    tick();
    bus1.ack_i = 1'b0;
    chk({p, "_done_after_ack"}, 32'(bus1.done_o), 32'd0);
    chk({p, "_dz_after_ack"}, 32'(bus1.div_zero_o), 32'd0);
    tick();
  endtask

  initial begin
    int lat;
    int seen;
    int bad;

    //          sgn   dividend      divisor       quotient      remainder     z     lat busy
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 34, 33};
    vecs[1] = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34, 33};
    vecs[2] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 33};
    vecs[3] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 34, 33};
    vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34, 33};
    vecs[5] = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1,  0};

    rst = 1'b1;
    {bus1.start_i, bus1.signed_i, bus1.cancel_i, bus1.ack_i} = '0;
    {bus4.start_i, bus4.signed_i, bus4.cancel_i, bus4.ack_i} = '0;
    bus1.dividend_i = '0; bus1.divisor_i = '0;
    bus4.dividend_i = '0; bus4.divisor_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_busy", 32'(bus1.busy_o), 32'd0);
    chk("rst_done", 32'(bus1.done_o), 32'd0);
    chk("rst_dz", 32'(bus1.div_zero_o), 32'd0);
    chk("rst_quot", bus1.quotient_o, 32'd0);
    chk("rst_rem", bus1.remainder_o, 32'd0);
    chk("rst4_done", 32'(bus4.done_o), 32'd0);
    chk("rst4_quot", bus4.quotient_o, 32'd0);

    // Cancel ten cycles into CALC.
    bus1.dividend_i = 32'h12345678;
    bus1.divisor_i  = 32'd3;
    bus1.start_i    = 1'b1;
    tick();
    bus1.start_i = 1'b0;
    repeat (10) tick();
    chk("cancel_busy_before", 32'(bus1.busy_o), 32'd1);
    bus1.cancel_i = 1'b1;
    tick();
    bus1.cancel_i = 1'b0;
    chk("cancel_busy_after", 32'(bus1.busy_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus1.done_o || bus1.busy_o) seen++;
    end
    chk("cancel_no_done", 32'(seen), 32'd0);
    chk("cancel_quot_kept", bus1.quotient_o, 32'd0);
    chk("cancel_rem_kept", bus1.remainder_o, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Cancel with start in IDLE is rejected.
    bus1.dividend_i = 32'd9;
    bus1.divisor_i  = 32'd3;
    bus1.start_i    = 1'b1;
    bus1.cancel_i   = 1'b1;
    tick();
    bus1.start_i  = 1'b0;
    bus1.cancel_i = 1'b0;
    repeat (3) tick();
    chk("start_cancel_busy", 32'(bus1.busy_o), 32'd0);
    chk("start_cancel_done", 32'(bus1.done_o), 32'd0);

    // BITS_PER_CYCLE = 4: 1000/33.
    bus4.dividend_i = 32'd1000;
    bus4.divisor_i  = 32'd33;
    bus4.start_i    = 1'b1;
    tick();
    bus4.start_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      tick();
      if (bus4.done_o) lat = c;
    end
    chk("bpc4_latency", 32'(lat), 32'd10);
    chk("bpc4_quotient", bus4.quotient_o, 32'd30);
    chk("bpc4_remainder", bus4.remainder_o, 32'd10);
    chk("bpc4_div_zero", 32'(bus4.div_zero_o), 32'd0);

    // Hold ack low for five cycles, with a stray start in the middle.
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        bus4.dividend_i = 32'd77;
        bus4.divisor_i  = 32'd5;
        bus4.start_i    = 1'b1;
      end
      tick();
      bus4.start_i = 1'b0;
      if (!bus4.done_o || bus4.quotient_o != 32'd30 || bus4.remainder_o != 32'd10 || bus4.busy_o)
        bad++;
    end
    chk("bpc4_hold_stable", 32'(bad), 32'd0);
    bus4.ack_i = 1'b1;
    tick();
    bus4.ack_i = 1'b0;
    chk("bpc4_done_after_ack", 32'(bus4.done_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus4.busy_o || bus4.done_o) seen++;
    end
    chk("bpc4_start_not_queued", 32'(seen), 32'd0);
    chk("bpc4_quot_kept", bus4.quotient_o, 32'd30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
